// File: rtl/rx_symbol_lock_packer.sv
// COM (K28.5) symbol-lock FSM and 8/16/32-bit receive word packer.
// Optional macro RX_SKP_DROP_EN: while locked, valid SKP (K28.0) bytes are dropped instead of packed.
module rx_symbol_lock_packer #(
    parameter int LOCK_COMS = 2,
    parameter int ERR_MAX   = 4,
    parameter int GOOD_DEC  = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic [1:0]       dataS,
    input  logic [7:0]       dataIn,
    input  logic             k_in,
    input  logic             invalid_in,
    output logic [31:0]      dataOut,
    output logic [3:0]       k_mask,
    output logic             word_valid,
    output logic             word_err,
    output logic             lock,
    output logic [CNT_W-1:0] sym_err_total
);
    // state | meaning
    // UNLOCKED | hunting for the first COM
    // ALIGN    | counting consecutive COMs toward lock
    // LOCKED   | packing bytes, tracking symbol errors
    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ALIGN    = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    localparam int EW = $clog2(ERR_MAX + 1);
    localparam int GW = $clog2(GOOD_DEC + 1);
    localparam int CW = $clog2(LOCK_COMS + 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    com_cnt_q, com_cnt_d;
    logic [EW-1:0]    err_cnt_q, err_cnt_d;
    logic [GW-1:0]    good_q, good_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       last_q, last_d;
    logic [31:0]      acc_data_q, acc_data_d;
    logic [3:0]       acc_k_q, acc_k_d;
    logic             acc_err_q, acc_err_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [3:0]       out_k_q, out_k_d;
    logic             out_err_q, out_err_d;
    logic             wv_q, wv_d;
    logic [CNT_W-1:0] sym_q, sym_d;

    logic        is_com, is_skp, do_pack, pk_err;
    logic [1:0]  sel_last, pk_last;
    logic [31:0] pk_data;
    logic [3:0]  pk_k;

    assign is_com = enb & k_in & (dataIn == 8'hBC) & ~invalid_in;
`ifdef RX_SKP_DROP_EN
    assign is_skp = enb & k_in & (dataIn == 8'h1C) & ~invalid_in;
`else
    assign is_skp = 1'b0;
`endif

    always_comb begin
        case (dataS)
            2'b01:   sel_last = 2'd1;
            2'b10:   sel_last = 2'd3;
            default: sel_last = 2'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        com_cnt_d  = com_cnt_q;
        err_cnt_d  = err_cnt_q;
        good_d     = good_q;
        idx_d      = idx_q;
        last_d     = last_q;
        acc_data_d = acc_data_q;
        acc_k_d    = acc_k_q;
        acc_err_d  = acc_err_q;
        out_data_d = out_data_q;
        out_k_d    = out_k_q;
        out_err_d  = out_err_q;
        wv_d       = 1'b0;
        sym_d      = sym_q;
        do_pack    = 1'b0;

        pk_data = (idx_q == 2'd0) ? 32'd0 : acc_data_q;
        pk_k    = (idx_q == 2'd0) ? 4'd0 : acc_k_q;
        pk_err  = ((idx_q != 2'd0) & acc_err_q) | invalid_in;
        pk_data[{idx_q, 3'b000} +: 8] = dataIn;
        pk_k[idx_q] = k_in;
        pk_last = (idx_q == 2'd0) ? sel_last : last_q;

        case (state_q)
            ST_LOCKED: begin
                if (enb && invalid_in) begin
                    good_d = '0;
                    if (sym_q != '1) sym_d = sym_q + 1'b1;
                    if (err_cnt_q == EW'(ERR_MAX - 1)) begin
                        state_d   = ST_UNLOCKED;
                        err_cnt_d = '0;
                        com_cnt_d = '0;
                        idx_d     = 2'd0;
                    end else begin
                        err_cnt_d = err_cnt_q + 1'b1;
                        do_pack   = 1'b1;
                    end
                end else if (enb) begin
                    if (good_q == GW'(GOOD_DEC - 1)) begin
                        good_d = '0;
                        if (err_cnt_q != '0) err_cnt_d = err_cnt_q - 1'b1;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                    if (is_com && idx_q != 2'd0) begin
                        out_data_d = acc_data_q;
                        out_k_d    = acc_k_q;
                        out_err_d  = 1'b1;
                        wv_d       = 1'b1;
                        acc_data_d = {24'd0, dataIn};
                        acc_k_d    = 4'b0001;
                        acc_err_d  = 1'b0;
                        idx_d      = 2'd1;
                        // A 1-byte select here would need two words in one cycle; keep the old width instead.
                        last_d     = (sel_last == 2'd0) ? last_q : sel_last;
                    end else if (!is_skp) begin
                        do_pack = 1'b1;
                    end
                end
            end
            default: begin
                if (is_com) begin
                    if (com_cnt_q == CW'(LOCK_COMS - 1)) begin
                        state_d   = ST_LOCKED;
                        com_cnt_d = '0;
                        err_cnt_d = '0;
                        good_d    = '0;
                        idx_d     = 2'd0;
                    end else begin
                        state_d   = ST_ALIGN;
                        com_cnt_d = com_cnt_q + 1'b1;
                    end
                end else if (enb && invalid_in) begin
                    state_d   = ST_UNLOCKED;
                    com_cnt_d = '0;
                end
            end
        endcase

        if (do_pack) begin
            if (idx_q == pk_last) begin
                out_data_d = pk_data;
                out_k_d    = pk_k;
                out_err_d  = pk_err;
                wv_d       = 1'b1;
                idx_d      = 2'd0;
            end else begin
                acc_data_d = pk_data;
                acc_k_d    = pk_k;
                acc_err_d  = pk_err;
                idx_d      = idx_q + 2'd1;
                if (idx_q == 2'd0) last_d = sel_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_UNLOCKED;
            com_cnt_q  <= '0;
            err_cnt_q  <= '0;
            good_q     <= '0;
            idx_q      <= 2'd0;
            last_q     <= 2'd0;
            acc_data_q <= 32'd0;
            acc_k_q    <= 4'd0;
            acc_err_q  <= 1'b0;
            out_data_q <= 32'd0;
            out_k_q    <= 4'd0;
            out_err_q  <= 1'b0;
            wv_q       <= 1'b0;
            sym_q      <= '0;
        end else begin
            state_q    <= state_d;
            com_cnt_q  <= com_cnt_d;
            err_cnt_q  <= err_cnt_d;
            good_q     <= good_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            acc_data_q <= acc_data_d;
            acc_k_q    <= acc_k_d;
            acc_err_q  <= acc_err_d;
            out_data_q <= out_data_d;
            out_k_q    <= out_k_d;
            out_err_q  <= out_err_d;
            wv_q       <= wv_d;
            sym_q      <= sym_d;
        end
    end

    assign dataOut       = out_data_q;
    assign k_mask        = out_k_q;
    assign word_err      = out_err_q;
    assign word_valid    = wv_q;
    assign lock          = (state_q == ST_LOCKED);
    assign sym_err_total = sym_q;
endmodule

// File: tb/tb_rx_symbol_lock_packer.sv
// Bench for rx_symbol_lock_packer: directed plan steps plus random traffic against a byte-level model.
module tb_rx_symbol_lock_packer;
    localparam int LOCK_COMS = 2;
    localparam int ERR_MAX   = 4;
    localparam int GOOD_DEC  = 8;
    localparam int CNT_W     = 8;

    logic        clk = 1'b0, rst = 1'b0, enb = 1'b0;
    logic [1:0]  dataS = 2'd0;
    logic [7:0]  dataIn = 8'd0;
    logic        k_in = 1'b0, invalid_in = 1'b0;
    logic [31:0] dataOut;
    logic [3:0]  k_mask;
    logic        word_valid, word_err, lock;
    logic [CNT_W-1:0] sym_err_total;

    rx_symbol_lock_packer #(.LOCK_COMS(LOCK_COMS), .ERR_MAX(ERR_MAX), .GOOD_DEC(GOOD_DEC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enb(enb), .dataS(dataS), .dataIn(dataIn), .k_in(k_in),
        .invalid_in(invalid_in), .dataOut(dataOut), .k_mask(k_mask), .word_valid(word_valid),
        .word_err(word_err), .lock(lock), .sym_err_total(sym_err_total));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    // Reference model: lock flag, counters, and the list of bytes in the current word.
    bit          m_locked;
    int          m_com, m_err, m_good, m_cnt, m_width, m_sym;
    logic [7:0]  m_b[4];
    logic        m_k[4];
    bit          m_werr;
    logic [31:0] e_data;
    logic [3:0]  e_k;
    logic        e_err, e_wv;

    function automatic int width_of(input logic [1:0] s);
        return (s == 2'b01) ? 2 : (s == 2'b10) ? 4 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_com = 0; m_err = 0; m_good = 0; m_cnt = 0; m_width = 1; m_sym = 0; m_werr = 0;
        e_data = 32'd0; e_k = 4'd0; e_err = 1'b0; e_wv = 1'b0;
    endtask

    task automatic model_emit(input bit flush);
        e_data = 32'd0; e_k = 4'd0;
        for (int i = 0; i < m_cnt; i++) begin
            e_data[8*i +: 8] = m_b[i];
            e_k[i] = m_k[i];
        end
        e_err = m_werr | flush;
        e_wv  = 1'b1;
        m_cnt = 0;
    endtask

    task automatic model_push(input logic [7:0] d, input logic k, input logic inv);
        if (m_cnt == 0) begin
            m_width = width_of(dataS);
            m_werr  = 0;
        end
        m_b[m_cnt] = d; m_k[m_cnt] = k; m_werr = m_werr | inv;
        m_cnt++;
        if (m_cnt == m_width) model_emit(0);
    endtask

    task automatic model_step();
        bit com, skp;
        e_wv = 1'b0;
        if (!enb) return;
        com = k_in && dataIn == 8'hBC && !invalid_in;
`ifdef RX_SKP_DROP_EN
        skp = k_in && dataIn == 8'h1C && !invalid_in;
`else
        skp = 0;
`endif
        if (!m_locked) begin
            if (com) begin
                m_com++;
                if (m_com >= LOCK_COMS) begin
                    m_locked = 1; m_com = 0; m_err = 0; m_good = 0; m_cnt = 0;
                end
            end else if (invalid_in) m_com = 0;
        end else if (invalid_in) begin
            if (m_sym < (1 << CNT_W) - 1) m_sym++;
            m_good = 0;
            m_err++;
            if (m_err >= ERR_MAX) begin
                m_locked = 0; m_err = 0; m_cnt = 0; m_com = 0;
            end else model_push(dataIn, k_in, 1'b1);
        end else begin
            m_good++;
            if (m_good == GOOD_DEC) begin
                m_good = 0;
                if (m_err > 0) m_err--;
            end
            if (com && m_cnt > 0) begin
                model_emit(1);
                model_push(dataIn, k_in, 1'b0);
            end else if (!skp) model_push(dataIn, k_in, 1'b0);
        end
    endtask

    task automatic check_all();
        chk("word_valid", 32'(word_valid), 32'(e_wv));
        chk("lock", 32'(lock), 32'(m_locked));
        chk("sym_err_total", 32'(sym_err_total), 32'(m_sym));
        chk("dataOut", dataOut, e_data);
        chk("k_mask", 32'(k_mask), 32'(e_k));
        chk("word_err", 32'(word_err), 32'(e_err));
    endtask

    task automatic send(input logic [7:0] d, input logic k, input logic inv, input logic en);
        @(negedge clk);
        enb = en; dataIn = d; k_in = k; invalid_in = inv;
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask

    task automatic relock();
        send(8'hBC, 1'b1, 1'b0, 1'b1);
        send(8'hBC, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] d;
        logic k, inv, en;
        int r;
        model_reset();
        #1 check_all();
        @(negedge clk) rst = 1'b1;

        // acquisition
        dataS = 2'b00;
        send(8'hBC, 1'b1, 1'b0, 1'b1);
        chk("lock_after_1st_com", 32'(lock), 32'd0);
        send(8'hBC, 1'b1, 1'b0, 1'b1);
        chk("lock_acq", 32'(lock), 32'd1);

        // 8-bit words
        send(8'h00, 1'b0, 1'b0, 1'b1);
        send(8'hCC, 1'b0, 1'b0, 1'b1);
        chk("w8_cc", dataOut, 32'h0000_00CC);
        send(8'hAB, 1'b0, 1'b0, 1'b1);
        send(8'h25, 1'b0, 1'b0, 1'b1);
        chk("w8_25", dataOut, 32'h0000_0025);

        // 16 and 32-bit words
        dataS = 2'b01;
        send(8'hCD, 1'b0, 1'b0, 1'b1);
        send(8'hAB, 1'b0, 1'b0, 1'b1);
        chk("w16", dataOut, 32'h0000_ABCD);
        chk("w16_valid", 32'(word_valid), 32'd1);
        dataS = 2'b10;
        send(8'h6F, 1'b0, 1'b0, 1'b1);
        send(8'h45, 1'b0, 1'b0, 1'b1);
        send(8'h23, 1'b0, 1'b0, 1'b1);
        send(8'hDE, 1'b0, 1'b0, 1'b1);
        chk("w32", dataOut, 32'hDE23_456F);

        // COM flush of a partial word
        send(8'h11, 1'b0, 1'b0, 1'b1);
        send(8'h22, 1'b0, 1'b0, 1'b1);
        send(8'hBC, 1'b1, 1'b0, 1'b1);
        chk("flush_data", dataOut, 32'h0000_2211);
        chk("flush_err", 32'(word_err), 32'd1);
        send(8'h33, 1'b0, 1'b0, 1'b1);
        send(8'h44, 1'b0, 1'b0, 1'b1);
        send(8'h55, 1'b0, 1'b0, 1'b1);
        chk("post_flush_data", dataOut, 32'h5544_33BC);
        chk("post_flush_k", 32'(k_mask), 32'h1);

        // width change mid-word and idle cycles
        send(8'hA1, 1'b0, 1'b0, 1'b1);
        send(8'hA2, 1'b0, 1'b0, 1'b1);
        dataS = 2'b00;
        send(8'hA3, 1'b0, 1'b0, 1'b1);
        send(8'hA4, 1'b0, 1'b0, 1'b1);
        chk("midword_width", dataOut, 32'hA4A3_A2A1);
        dataS = 2'b01;
        send(8'h01, 1'b0, 1'b0, 1'b1);
        repeat (3) send(8'hFF, 1'b1, 1'b1, 1'b0);
        send(8'h02, 1'b0, 1'b0, 1'b1);
        chk("enb_hold", dataOut, 32'h0000_0201);

        // error count: 3 good between invalids loses lock
        dataS = 2'b00;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) send(8'(16 + j), 1'b0, 1'b0, 1'b1);
            send(8'hEE, 1'b0, 1'b1, 1'b1);
        end
        chk("err_unlock", 32'(lock), 32'd0);
        chk("err_total4", 32'(sym_err_total), 32'd4);
        relock();
        for (int i = 0; i < 4; i++) begin
            send(8'hEE, 1'b0, 1'b1, 1'b1);
            for (int j = 0; j < 8; j++) send(8'(32 + j), 1'b0, 1'b0, 1'b1);
        end
        chk("err_keep_lock", 32'(lock), 32'd1);
        chk("err_total8", 32'(sym_err_total), 32'd8);

        // asynchronous reset mid-word
        dataS = 2'b10;
        send(8'h77, 1'b0, 1'b0, 1'b1);
        send(8'h88, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rst_data", dataOut, 32'd0);
        chk("rst_lock", 32'(lock), 32'd0);
        chk("rst_sym", 32'(sym_err_total), 32'd0);
        check_all();
        @(negedge clk) rst = 1'b1;
        relock();

`ifdef RX_SKP_DROP_EN
        dataS = 2'b10;
        send(8'h01, 1'b0, 1'b0, 1'b1);
        send(8'h1C, 1'b1, 1'b0, 1'b1);
        send(8'h02, 1'b0, 1'b0, 1'b1);
        send(8'h03, 1'b0, 1'b0, 1'b1);
        send(8'h04, 1'b0, 1'b0, 1'b1);
        chk("skp_drop", dataOut, 32'h0403_0201);
`endif

        // random traffic
        for (int seg = 0; seg < 6; seg++) begin
            dataS = 2'($urandom_range(0, 3));
            for (int c = 0; c < 250; c++) begin
                en = ($urandom_range(0, 9) != 0);
                r  = int'($urandom_range(0, 99));
                if (r < 12) begin d = 8'hBC; k = 1'b1; end
                else if (r < 17) begin d = 8'h1C; k = 1'b1; end
                else begin d = 8'($urandom); k = (r < 22); end
                inv = ($urandom_range(0, (seg < 3) ? 40 : 8) == 0);
                if (d == 8'hBC && k && !inv && m_locked && m_cnt > 0 && width_of(dataS) == 1) k = 1'b0;
                send(d, k, inv, en);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
